axi_lite_master: RTL and testbench

AXI4-Lite initiator that turns single-word commands from a simple valid/ready command port into AXI4-Lite read or write transactions, then returns the data and response on a valid/ready response port. It is the master-side counterpart of the team's UART AXI-Lite peripheral and drives such responders on bench and board. It handles one transaction at a time, with no outstanding overlap.

---
 rtl/axi_lite_master.sv | 212 +++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one command in, one AXI4-Lite read or write out, one response back.
// Optional watchdog abort is compiled in with `define AXI_LITE_MASTER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR      | AW and W offered, each dropped on its own handshake
// WRESP   | bready high, waiting for B
// RADDR   | AR offered
// RDATA   | rready high, waiting for R
// RESP    | response held until rsp_ready
module axi_lite_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_aresetn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                   cmd_wdata,
    input  logic [3:0]                    cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_write,
    output logic [31:0]                   rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    output logic [31:0]                   m_axi_wdata,
    output logic [3:0]                    m_axi_wstrb,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    input  logic [1:0]                    m_axi_bresp,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [31:0]                   m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    logic [2:0]                    r_state;
    logic                          r_cmd_ready;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]                   r_wdata;
    logic [3:0]                    r_wstrb;
    logic                          r_awvalid;
    logic                          r_wvalid;
    logic                          r_bready;
    logic                          r_arvalid;
    logic                          r_rready;
    logic                          r_rsp_valid;
    logic                          r_rsp_write;
    logic [31:0]                   r_rsp_rdata;
    logic [1:0]                    r_rsp_resp;
    logic                          w_aw_done;
    logic                          w_w_done;
    logic                          w_abort;

    // A channel counts as done if it was already handshaken or handshakes this cycle.
    assign w_aw_done = !r_awvalid || m_axi_awready;
    assign w_w_done  = !r_wvalid  || m_axi_wready;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] r_wdog;
    logic              w_busy;

    assign w_busy  = (r_state != S_IDLE) && (r_state != S_RESP);
    assign w_abort = w_busy && (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_wdog <= '0;
        end else if (r_state == S_IDLE) begin
            r_wdog <= '0;
        end else if (w_busy && !w_abort) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_abort          = 1'b0;
`endif

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
        end else if (w_abort) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b11;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_cmd_ready && cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_wstrb     <= cmd_wstrb;
                        r_rsp_write <= cmd_write;
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RADDR;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_WR: begin
                    if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
                    if (r_wvalid && m_axi_wready)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (m_axi_bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= m_axi_bresp;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RADDR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (m_axi_rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= m_axi_rdata;
                        r_rsp_resp  <= m_axi_rresp;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_write     = r_rsp_write;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_bready  = r_bready;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: vector table plus random transactions against a cycle-timing model
// of the expected AXI waveform; a reactive slave answers with per-transaction delays.
module tb_axi_lite_master;

    localparam int AW = 4;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic          clk;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          any_out;

    int errs   = 0;
    int checks = 0;

    axi_lite_master #(.C_M_AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
    );

    assign any_out = |{cmd_ready, awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid,
                       araddr, arprot, rready, rsp_valid, rsp_write, rsp_rdata, rsp_resp};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "global timeout");
    end

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_d, w_d, b_d, ar_d, r_d, rsp_d;
        logic [1:0]  sresp;
        logic [31:0] srdata;
        bit          junk;
        bit          exp_write;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_slave();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        rsp_ready = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge with cmd_valid low.
    task automatic run_txn(input vec_t v);
        int  d_wr, b_edge, a_edge, r_edge, first, redge, hs_n;
        int  aw_seen, w_seen, ar_seen, rsp_seen, aw_n, w_n, ar_n, b_cnt, r_cnt;
        bit  acc, done;
        d_wr   = 1 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d);
        b_edge = d_wr + 1 + v.b_d;
        a_edge = 1 + v.ar_d;
        r_edge = a_edge + 1 + v.r_d;
        first  = (v.wr ? b_edge : r_edge) + 1;
        redge  = first + v.rsp_d;

        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        acc = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (cmd_ready) begin acc = 1'b1; break; end
            @(negedge clk);
        end
        chk("cmd_accept", 64'(acc), 64'(1));
        if (!acc) begin cmd_valid = 1'b0; return; end
        @(posedge clk);

        aw_seen = 0; w_seen = 0; ar_seen = 0; rsp_seen = 0;
        aw_n = -1; w_n = -1; ar_n = -1; b_cnt = 0; r_cnt = 0;
        done = 1'b0; hs_n = -1;
        for (int n = 1; n <= 200 && !done; n++) begin
            @(negedge clk);
            if (v.junk) begin
                cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = 4'($urandom);
                cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));
            chk("awvalid", 64'(awvalid), 64'(v.wr && n <= 1 + v.aw_d));
            chk("wvalid", 64'(wvalid), 64'(v.wr && n <= 1 + v.w_d));
            chk("bready", 64'(bready), 64'(v.wr && n >= d_wr + 1 && n <= b_edge));
            chk("arvalid", 64'(arvalid), 64'(!v.wr && n <= a_edge));
            chk("rready", 64'(rready), 64'(!v.wr && n >= a_edge + 1 && n <= r_edge));
            chk("rsp_valid", 64'(rsp_valid), 64'(n >= first));
            chk("prot", 64'({awprot, arprot}), 64'(0));
            if (awvalid) chk("awaddr", 64'(awaddr), 64'(v.addr));
            if (wvalid)  chk("wdata_wstrb", 64'({wdata, wstrb}), 64'({v.wdata, v.wstrb}));
            if (arvalid) chk("araddr", 64'(araddr), 64'(v.addr));
            if (rsp_valid)
                chk("rsp_payload", 64'({rsp_write, rsp_rdata, rsp_resp}),
                    64'({v.exp_write, v.exp_rdata, v.exp_resp}));

            awready = awvalid && (aw_seen >= v.aw_d);
            if (awvalid) aw_seen++;
            if (awvalid && awready) aw_n = n;
            wready = wvalid && (w_seen >= v.w_d);
            if (wvalid) w_seen++;
            if (wvalid && wready) w_n = n;
            bvalid = (aw_n > 0) && (w_n > 0) && (b_cnt == 0) &&
                     (n > ((aw_n > w_n) ? aw_n : w_n) + v.b_d);
            bresp = bvalid ? v.sresp : 2'($urandom);
            if (bvalid && bready) b_cnt++;
            arready = arvalid && (ar_seen >= v.ar_d);
            if (arvalid) ar_seen++;
            if (arvalid && arready) ar_n = n;
            rvalid = (ar_n > 0) && (r_cnt == 0) && (n > ar_n + v.r_d);
            rdata  = rvalid ? v.srdata : $urandom;
            rresp  = rvalid ? v.sresp : 2'($urandom);
            if (rvalid && rready) r_cnt++;
            rsp_ready = rsp_valid && (rsp_seen >= v.rsp_d);
            if (rsp_valid) rsp_seen++;
            if (rsp_valid && rsp_ready) begin done = 1'b1; hs_n = n; end
        end
        chk("rsp_handshake", 64'(done), 64'(1));
        chk("rsp_edge", 64'(hs_n), 64'(redge));
        chk("b_count", 64'(b_cnt), 64'(v.wr ? 1 : 0));
        chk("r_count", 64'(r_cnt), 64'(v.wr ? 0 : 1));
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        clear_slave();
        chk("cmd_ready_return", 64'(cmd_ready), 64'(1));
    endtask

    vec_t vecs[6];
    vec_t rv;

    initial begin
        vecs[0] = '{1'b1, 4'h4, 32'h0000_00A5, 4'hF, 0, 0, 0, 0, 0, 0,  2'b00, 32'h0,         1'b0, 1'b1, 32'h0,         2'b00};
        vecs[1] = '{1'b1, 4'hC, 32'hDEAD_BEEF, 4'h3, 3, 0, 0, 0, 0, 0,  2'b01, 32'h0,         1'b0, 1'b1, 32'h0,         2'b01};
        vecs[2] = '{1'b0, 4'h8, 32'h0,         4'h0, 0, 0, 0, 5, 5, 0,  2'b10, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 2'b10};
        vecs[3] = '{1'b0, 4'h0, 32'h0,         4'h0, 0, 0, 0, 0, 0, 10, 2'b00, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D, 2'b00};
        vecs[4] = '{1'b1, 4'h6, 32'h8000_0001, 4'h9, 0, 2, 3, 0, 0, 1,  2'b11, 32'h5555_AAAA, 1'b1, 1'b1, 32'h0,         2'b11};
        vecs[5] = '{1'b0, 4'hF, 32'h0,         4'h0, 0, 0, 0, 2, 0, 2,  2'b01, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF, 2'b01};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        clear_slave();
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", 64'(any_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", 64'(cmd_ready), 64'(0));
        @(posedge clk);
        #1 chk("ready_after_reset", 64'(cmd_ready), 64'(1));
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        for (int i = 0; i < 20; i++) begin
            rv.wr     = 1'($urandom);
            rv.addr   = 4'($urandom);
            rv.wdata  = $urandom;
            rv.wstrb  = 4'($urandom);
            rv.aw_d   = int'($urandom_range(0, 4));
            rv.w_d    = int'($urandom_range(0, 4));
            rv.b_d    = int'($urandom_range(0, 4));
            rv.ar_d   = int'($urandom_range(0, 4));
            rv.r_d    = int'($urandom_range(0, 4));
            rv.rsp_d  = int'($urandom_range(0, 3));
            rv.sresp  = 2'($urandom);
            rv.srdata = $urandom;
            rv.junk   = 1'($urandom);
            rv.exp_write = rv.wr;
            rv.exp_rdata = rv.wr ? 32'h0 : rv.srdata;
            rv.exp_resp  = rv.sresp;
            run_txn(rv);
        end

        // Reset while waiting for B: everything clears at once, no response follows.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        chk("wresp_bready", 64'(bready), 64'(1));
        #2 rst_n = 1'b0;
        #1 chk("midrst_outputs", 64'(any_out), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrst_ready_before_edge", 64'(cmd_ready), 64'(0));
        @(posedge clk);
        #1 chk("midrst_ready_after", 64'(cmd_ready), 64'(1));
        chk("midrst_no_rsp", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        run_txn(vecs[0]);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        begin
            int first_rsp;
            first_rsp = -1;
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h3;
            @(posedge clk);
            for (int n = 1; n <= 30; n++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                chk("to_arvalid", 64'(arvalid), 64'(n <= TO));
                if (rsp_valid && first_rsp < 0) first_rsp = n;
            end
            chk("to_rsp_cycle", 64'(first_rsp), 64'(TO + 1));
            chk("to_rsp_payload", 64'({rsp_resp, rsp_rdata}), 64'({2'b11, 32'h0}));
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            chk("to_ready_return", 64'(cmd_ready), 64'(1));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
